// File: rtl/proc_in_fifo_pkg.sv
// Shared definitions for the processor input FIFO stage.
//   - itr_state_e : interrupt engine states (IDLE=0, FIRE=1, WAIT=2)
//   - STAT_*_OFS  : status-word flag positions, counted upward from the
//                   bit just above the count field
package proc_in_fifo_pkg;

  typedef enum logic [1:0] {
    ITR_IDLE = 2'd0,
    ITR_FIRE = 2'd1,
    ITR_WAIT = 2'd2
  } itr_state_e;

  // Status word layout: {zero-ext, udf, full, empty, count}.
  localparam int STAT_EMPTY_OFS = 0;
  localparam int STAT_FULL_OFS  = 1;
  localparam int STAT_UDF_OFS   = 2;

endpackage

// File: rtl/proc_in_fifo_fifo_mem.sv
// fifo_mem: DEPTH x NUBITS register array for the input FIFO.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data; asynchronous, follows raddr with no latency
// The array is not reset: the pointers and count define what is valid.
module fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int NUBITS = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [NUBITS-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [NUBITS-1:0]        rdata
);

  logic [NUBITS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/proc_in_fifo.sv
// proc_in_fifo: input-side I/O stage feeding the processor's io_in.
// A producer pushes samples over valid/ready into a DEPTH-entry FIFO; the
// processor reads the head (popping it) or a status word through its
// addr_in/req_in read port. An interrupt engine pulses itr for one cycle
// whenever the fill level rises to ITRLVL.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   s_data/s_valid  - producer sample and valid
//   s_ready         - FIFO not full
//   addr_in/req_in  - processor input address and read strobe
//   io_in           - combinational read data for the addressed register
//   itr             - one-cycle interrupt pulse
module proc_in_fifo
  import proc_in_fifo_pkg::*;
#(
  parameter int NUBITS  = 16,
  parameter int DEPTH   = 8,
  parameter int NUIOIN  = 2,
  parameter int DATA_AD = 0,
  parameter int STAT_AD = 1,
  parameter int ITRLVL  = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUBITS-1:0]                              s_data,
  input  logic                                           s_valid,
  output logic                                           s_ready,
  input  logic [((NUIOIN > 1) ? $clog2(NUIOIN) : 1)-1:0] addr_in,
  input  logic                                           req_in,
  output logic [NUBITS-1:0]                              io_in,
  output logic                                           itr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;

  localparam logic [AW-1:0] DATA_A   = AW'(DATA_AD);
  localparam logic [AW-1:0] STAT_A   = AW'(STAT_AD);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ITRLVL_C = CW'(ITRLVL);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              udf_q, udf_d;
  itr_state_e        state_q;
  logic              itr_q;

  logic              full, empty;
  logic              push, pop_req, pop, stat_rd;
  logic [NUBITS-1:0] head;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign s_ready = !full;

  // Push depends only on the current fill, so a same-cycle pop never lets
  // a write into a full FIFO.
  assign push    = s_valid && !full;
  assign pop_req = req_in && (addr_in == DATA_A);
  // A word pushed this cycle is not yet visible, so a pop on an empty FIFO
  // underflows even when a push coincides.
  assign pop     = pop_req && !empty;
  assign stat_rd = req_in && (addr_in == STAT_A);

  fifo_mem #(
    .DEPTH  (DEPTH),
    .NUBITS (NUBITS)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (s_data),
    .raddr (rptr_q),
    .rdata (head)
  );

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    udf_d   = udf_q;
    if (push) wptr_d = wptr_q + PTR_ONE;
    if (pop)  rptr_d = rptr_q + PTR_ONE;
    count_d = count_q + CW'(push) - CW'(pop);
    // Status and data addresses are distinct, so clear and set never collide.
    if (stat_rd)
      udf_d = 1'b0;
    else if (pop_req && empty)
      udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      udf_q   <= udf_d;
    end
  end

  // Read mux: io_in shows the pre-update state, so a status read returns
  // udf before it is cleared at the same edge.
  always_comb begin
    io_in = '0;
    if (addr_in == DATA_A) begin
      if (!empty) io_in = head;
    end else if (addr_in == STAT_A) begin
      io_in[CW-1:0]               = count_q;
      io_in[CW + STAT_EMPTY_OFS]  = empty;
      io_in[CW + STAT_FULL_OFS]   = full;
      io_in[CW + STAT_UDF_OFS]    = udf_q;
    end
  end

  // Interrupt engine. Transitions look at count_d so the pulse lands in the
  // cycle right after the edge that brought the level up to ITRLVL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ITR_IDLE;
      itr_q   <= 1'b0;
    end else begin
      itr_q <= 1'b0;
      case (state_q)
        ITR_IDLE: begin
          if (count_d >= ITRLVL_C) begin
            state_q <= ITR_FIRE;
            itr_q   <= 1'b1;
          end
        end
        ITR_FIRE: state_q <= ITR_WAIT;
        ITR_WAIT: begin
          if (count_d < ITRLVL_C) state_q <= ITR_IDLE;
        end
        default:  state_q <= ITR_IDLE;
      endcase
    end
  end

  assign itr = itr_q;

endmodule

// File: tb/tb_proc_in_fifo.sv
module tb_proc_in_fifo;

  localparam logic [0:0] DATA_AD = 1'b0;
  localparam logic [0:0] STAT_AD = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [0:0]  addr_in;
  logic        req_in;
  logic [15:0] io_in;
  logic        itr;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q [$];

  proc_in_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .addr_in (addr_in),
    .req_in  (req_in),
    .io_in   (io_in),
    .itr     (itr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%04h", name, act);
    end
  endtask

  task automatic push(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic rd(input logic [0:0] a, input logic [15:0] e);
    addr_in = a;
    req_in  = 1'b1;
    exp_q.push_back(e);
    tick();
    req_in  = 1'b0;
  endtask

  // Monitor: every processor read is scored against the queued expectation.
  always @(negedge clk) begin
    if (req_in) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL read: got 0x%04h, no expectation queued", io_in);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (io_in !== e) begin
          fails++;
          $display("FAIL read addr=%0d: got 0x%04h, expected 0x%04h", addr_in, io_in, e);
        end else begin
          $display("ok   read addr=%0d: 0x%04h", addr_in, io_in);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_data = '0; s_valid = 1'b0; addr_in = DATA_AD; req_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_s_ready", {15'd0, s_ready}, 16'h0001);
    check("rst_itr", {15'd0, itr}, 16'h0000);
    rd(STAT_AD, 16'h0010);

    // In-order push/pop
    s_valid = 1'b1;
    s_data = 16'h0011; tick();
    s_data = 16'h0022; tick();
    s_data = 16'h0033; tick();
    s_valid = 1'b0;
    rd(DATA_AD, 16'h0011);
    rd(DATA_AD, 16'h0022);
    rd(DATA_AD, 16'h0033);
    rd(STAT_AD, 16'h0010);

    // Fill to DEPTH, back-pressure, one pop releases
    for (int i = 0; i < 8; i++) begin
      push(16'h0100 + 16'(i));
      check($sformatf("fill_s_ready_%0d", i), {15'd0, s_ready}, (i < 7) ? 16'h0001 : 16'h0000);
    end
    s_data = 16'hDEAD; s_valid = 1'b1;
    tick(); tick();
    check("full_hold_s_ready", {15'd0, s_ready}, 16'h0000);
    s_valid = 1'b0;
    rd(STAT_AD, 16'h0028);
    rd(DATA_AD, 16'h0100);
    check("pop_s_ready", {15'd0, s_ready}, 16'h0001);
    for (int i = 1; i < 8; i++) rd(DATA_AD, 16'h0100 + 16'(i));
    rd(STAT_AD, 16'h0010);

    // Interrupt engine
    for (int i = 0; i < 4; i++) begin
      push(16'h00A0 + 16'(i));
      check($sformatf("itr_push_%0d", i), {15'd0, itr}, (i == 3) ? 16'h0001 : 16'h0000);
    end
    tick();
    check("itr_one_cycle", {15'd0, itr}, 16'h0000);
    push(16'h00A4);
    check("itr_no_refire", {15'd0, itr}, 16'h0000);
    rd(DATA_AD, 16'h00A0);
    rd(DATA_AD, 16'h00A1);
    check("itr_after_pop", {15'd0, itr}, 16'h0000);
    push(16'h00A5);
    check("itr_second_pulse", {15'd0, itr}, 16'h0001);
    tick();
    check("itr_second_end", {15'd0, itr}, 16'h0000);
    rd(DATA_AD, 16'h00A2);
    rd(DATA_AD, 16'h00A3);
    rd(DATA_AD, 16'h00A4);
    rd(DATA_AD, 16'h00A5);

    // Underflow and sticky udf
    rd(DATA_AD, 16'h0000);
    rd(STAT_AD, 16'h0050);
    rd(STAT_AD, 16'h0010);

    // Same-cycle push and pop on empty FIFO
    s_data = 16'h00AA; s_valid = 1'b1;
    addr_in = DATA_AD; req_in = 1'b1;
    exp_q.push_back(16'h0000);
    tick();
    s_valid = 1'b0; req_in = 1'b0;
    rd(STAT_AD, 16'h0041);
    rd(DATA_AD, 16'h00AA);

    // Asynchronous reset with words queued
    for (int i = 0; i < 5; i++) push(16'h0200 + 16'(i));
    addr_in = STAT_AD;
    #1 check("pre_rst_stat", io_in, 16'h0005);
    #1 rst = 1'b1;
    #1 check("async_rst_stat", io_in, 16'h0010);
    check("async_rst_s_ready", {15'd0, s_ready}, 16'h0001);
    check("async_rst_itr", {15'd0, itr}, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Asynchronous reset during the interrupt pulse
    for (int i = 0; i < 4; i++) push(16'h0300 + 16'(i));
    check("pre_rst_itr", {15'd0, itr}, 16'h0001);
    #1 rst = 1'b1;
    #1 check("async_rst_itr_pulse", {15'd0, itr}, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    rd(STAT_AD, 16'h0010);
    rd(DATA_AD, 16'h0000);

    tick();
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
